// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared widths, FSM state type and window check for the APB RAM responder
package apb_mem_pkg;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  typedef enum logic {IDLE, ACCESS} apb_mem_state_e;
  function automatic logic addr_err(input logic [31:0] offset, input int unsigned depth);
    return offset >= 32'(4 * depth) || offset[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/sram_1rw_be.sv
// sram_1rw_be: single-port synchronous RAM with byte enables, registered read-first output
module sram_1rw_be import apb_mem_pkg::*; #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [APB_STRB_W-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [APB_DATA_W-1:0]    wdata,
  output logic [APB_DATA_W-1:0]    rdata
);
  logic [APB_DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < APB_STRB_W; b++)
        if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB responder serving a word-addressed RAM window with programmable wait states
module apb_mem_slave import apb_mem_pkg::*; #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [31:0]           paddr,
  input  logic                  pwrite,
  input  logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_STRB_W-1:0] pwstrb,
  output logic                  pready,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pslverr
);
  localparam int AW = $clog2(DEPTH_WORDS);
  apb_mem_state_e        state;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_DATA_W-1:0] rdata;
  logic [APB_STRB_W-1:0] strb_q;
  logic [AW-1:0]         idx_q;
  logic [31:0]           offset;
  logic                  setup;
  logic                  done;
  logic                  we;
  assign offset  = paddr - BASE_ADDR;
  assign setup   = state == IDLE && psel && !penable;
  assign pready  = state == ACCESS && cnt == 4'd0;
  assign done    = psel && penable && pready;
  assign we      = done && wr_q && !err_q && !rst;
  assign prdata  = pready && !wr_q && !err_q ? rdata : '0;
  assign pslverr = pready && err_q;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
    end else if (setup) begin
      state   <= ACCESS;
      cnt     <= 4'(WAIT_CYCLES);
      wr_q    <= pwrite;
      err_q   <= addr_err(offset, DEPTH_WORDS);
      wdata_q <= pwdata;
      strb_q  <= pwstrb;
      idx_q   <= offset[AW+1:2];
    end else if (state == ACCESS) begin
      if (!psel || done) state <= IDLE;
      else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  // read is issued in setup and held by the RAM output register through the wait states
  sram_1rw_be #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (setup || we),
    .we    (we),
    .be    (strb_q),
    .addr  (setup ? offset[AW+1:2] : idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed APB sequences on a zero-wait and a three-wait instance with a scoreboard
module tb_apb_mem_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel0 = 1'b0;
  logic        psel3 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pwstrb = '0;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [31:0] prdata0, prdata3;
  int          total = 0;
  int          bad = 0;
  typedef struct {logic [31:0] d; logic e;} exp_t;
  exp_t        sb[$];
  logic [31:0] mdl [bit [32:0]];

  always #5 clk = ~clk;

  apb_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));
  apb_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3));

  function automatic logic rdy(input bit u);
    return u ? pready3 : pready0;
  endfunction
  function automatic logic serr(input bit u);
    return u ? pslverr3 : pslverr0;
  endfunction
  function automatic logic [31:0] rdat(input bit u);
    return u ? prdata3 : prdata0;
  endfunction

  task automatic sel(input bit u, input logic v);
    if (u) psel3 = v;
    else psel0 = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit u, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
    exp_t        x;
    logic        e;
    logic [31:0] m;
    int          n;
    bit          got;
    e = (a - BASE) >= 32'd4096 || a[1:0] != 2'b00;
    x.e = e;
    x.d = (wr || e) ? 32'h0 : mdl[{u, a}];
    @(negedge clk);
    sel(u, 1'b1);
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    pwstrb = s;
    sb.push_back(x);
    n = 1;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      penable = 1'b1;
      pwdata = ~d;
      pwstrb = ~s;
      if (rdy(u)) begin
        got = 1;
        x = sb.pop_front();
        chk({tag, " len"}, 32'(n), u ? 32'd5 : 32'd2);
        chk({tag, " err"}, 32'(serr(u)), 32'(x.e));
        chk({tag, " rdata"}, rdat(u), x.d);
        if (wr && !e) begin
          m = mdl.exists({u, a}) ? mdl[{u, a}] : 32'h0;
          for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
          mdl[{u, a}] = m;
        end
      end
    end
    if (!got) chk({tag, " pready seen"}, 32'(got), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    psel0 = 1'b0;
    psel3 = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst pready0", 32'(pready0), 32'd0);
    chk("rst pslverr0", 32'(pslverr0), 32'd0);
    chk("rst prdata0", prdata0, 32'h0);
    chk("rst pready3", 32'(pready3), 32'd0);
    rst = 1'b0;
    xfer(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, "w0 beef");
    xfer(0, 0, 32'h8000_0010, 32'h0, 4'hF, "r0 beef");
    idle();
    xfer(0, 1, 32'h8000_0000, 32'h1122_3344, 4'hF, "w0 full");
    xfer(0, 1, 32'h8000_0000, 32'hAABB_CCDD, 4'b0101, "w0 strb");
    xfer(0, 0, 32'h8000_0000, 32'h0, 4'hF, "r0 strb");
    xfer(0, 1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, "w0 below");
    xfer(0, 0, 32'h7FFF_FFFC, 32'h0, 4'hF, "r0 below");
    xfer(0, 1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, "w0 above");
    xfer(0, 0, 32'h8000_1000, 32'h0, 4'hF, "r0 above");
    xfer(0, 1, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF, "w0 misal");
    xfer(0, 0, 32'h8000_0002, 32'h0, 4'hF, "r0 misal");
    xfer(0, 0, 32'h8000_0000, 32'h0, 4'hF, "r0 after err");
    xfer(0, 0, 32'h8000_0010, 32'h0, 4'hF, "r0 beef again");
    idle();
    xfer(1, 1, 32'h8000_0020, 32'h1234_5678, 4'hF, "w3");
    xfer(1, 0, 32'h8000_0020, 32'h0, 4'hF, "r3 a");
    xfer(1, 0, 32'h8000_0020, 32'h0, 4'hF, "r3 b");
    xfer(1, 1, 32'h8000_0024, 32'h0BAD_F00D, 4'b1100, "w3 hi");
    idle();
    @(negedge clk);
    psel3 = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h8000_0020;
    pwdata = 32'hCAFE_F00D;
    pwstrb = 4'hF;
    @(negedge clk);
    chk("abort acc1 pready", 32'(pready3), 32'd0);
    penable = 1'b1;
    @(negedge clk);
    chk("abort acc2 pready", 32'(pready3), 32'd0);
    psel3 = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("abort after pready", 32'(pready3), 32'd0);
    xfer(1, 0, 32'h8000_0020, 32'h0, 4'hF, "r3 after abort");
    idle();
    @(negedge clk);
    psel3 = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h8000_0020;
    pwdata = 32'h5555_5555;
    pwstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid pready", 32'(pready3), 32'd0);
    chk("rst mid pslverr", 32'(pslverr3), 32'd0);
    chk("rst mid prdata", prdata3, 32'h0);
    rst = 1'b0;
    psel3 = 1'b0;
    penable = 1'b0;
    xfer(1, 0, 32'h8000_0020, 32'h0, 4'hF, "r3 after rst");
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
